load_align_unit: RTL and testbench

// Multi-cycle load unit between the core's memory stage and a word-wide data memory port.

---
 rtl/load_align_unit_pkg.sv | 38 +++
 rtl/load_align_unit_extend.sv | 44 ++++
 rtl/load_align_unit.sv | 172 +++++++++++++++++
 tb/tb_load_align_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: load-type codes, FSM state
// encodings and the access-size decode used by both the FSM and the merge path.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACC0  = 3'd1;
    localparam logic [2:0] ST_WAIT0 = 3'd2;
    localparam logic [2:0] ST_ACC1  = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // Access size in bytes; 0 marks a funct3 that is illegal for this XLEN.
    function automatic logic [3:0] load_size(input logic [2:0] funct3, input logic xlen64);
        logic [3:0] size;
        case (funct3)
            F3_LB, F3_LBU: size = 4'd1;
            F3_LH, F3_LHU: size = 4'd2;
            F3_LW:         size = 4'd4;
            F3_LD:         size = xlen64 ? 4'd8 : 4'd0;
            F3_LWU:        size = xlen64 ? 4'd4 : 4'd0;
            default:       size = 4'd0;
        endcase
        return size;
    endfunction

    function automatic logic load_signed(input logic [2:0] funct3);
        return ~funct3[2];
    endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// Combinational byte merge and extension: picks the loaded bytes out of one or
// two consecutive words and sign- or zero-extends them to XLEN.
module load_align_extend
    import load_align_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFB = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] word0_i,
    input  logic [XLEN-1:0] word1_i,
    input  logic [OFFB-1:0] off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    localparam logic XLEN64 = (XLEN == 64);

    logic [XLEN-1:0] low;
    logic [3:0]      size;
    logic            sign_bit;
    int              nbits;

    assign low  = XLEN'({word1_i, word0_i} >> {off_i, 3'b000});
    assign size = load_size(funct3_i, XLEN64);

    always_comb begin
        sign_bit = 1'b0;
        nbits    = 8 * int'(size);
        case (size)
            4'd1:    sign_bit = low[7];
            4'd2:    sign_bit = low[15];
            4'd4:    sign_bit = low[31];
            4'd8:    sign_bit = low[XLEN-1];
            default: sign_bit = 1'b0;
        endcase
        sign_bit = sign_bit & load_signed(funct3_i);
        data_o = '0;
        // A full-width load leaves nothing above nbits, so it passes through untouched.
        for (int i = 0; i < XLEN; i++) begin
            data_o[i] = (i < nbits) ? low[i] : sign_bit;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Multi-cycle load unit: issues one or two word-aligned reads per load, merges
// and extends the bytes, and returns the result on a valid/ready channel.
//
// state | meaning
// IDLE  | ready for a new load request
// ACC0  | first word read request on the memory port
// WAIT0 | waiting for first word data
// ACC1  | second word read request (word-crossing load only)
// WAIT1 | waiting for second word data
// RESP  | result held on resp_* until resp_ready
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_fault
);

    localparam int   W      = XLEN / 8;
    localparam int   OFFB   = $clog2(W);
    localparam logic XLEN64 = (XLEN == 64);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFFB-1:0]   off_q, off_d;
    logic              cross_q, cross_d;
    logic [XLEN-1:0]   word0_q, word0_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;

    logic [OFFB-1:0]   req_off;
    logic [3:0]        req_size;
    logic              req_illegal;
    logic              req_misaligned;
    logic [4:0]        req_span;
    logic              req_cross;

    logic [XLEN-1:0]   ext_w0;
    logic [XLEN-1:0]   ext_w1;
    logic [XLEN-1:0]   ext_data;

    assign req_off        = req_addr[OFFB-1:0];
    assign req_size       = load_size(req_funct3, XLEN64);
    assign req_illegal    = (req_size == 4'd0);
    assign req_misaligned = (req_off & OFFB'(req_size - 4'd1)) != '0;
    assign req_span       = 5'(req_off) + 5'(req_size);
    assign req_cross      = req_span > 5'(W);

    // Merge straight from mem_rdata on the cycle the last word arrives.
    assign ext_w0 = (state_q == ST_WAIT0) ? mem_rdata : word0_q;
    assign ext_w1 = (state_q == ST_WAIT1) ? mem_rdata : '0;

    load_align_extend #(
        .XLEN (XLEN)
    ) u_extend (
        .word0_i  (ext_w0),
        .word1_i  (ext_w1),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cross_d      = cross_q;
        word0_d      = word0_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    base_d   = {req_addr[ADDR_W-1:OFFB], {OFFB{1'b0}}};
                    funct3_d = req_funct3;
                    off_d    = req_off;
                    cross_d  = req_cross;
                    if (req_illegal || (req_misaligned && !MISALIGN_EN)) begin
                        resp_data_d  = '0;
                        resp_fault_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        resp_fault_d = 1'b0;
                        state_d      = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                if (mem_req_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_rvalid) begin
                    word0_d = mem_rdata;
                    if (cross_q) begin
                        state_d = ST_ACC1;
                    end else begin
                        resp_data_d = ext_data;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ACC1: begin
                if (mem_req_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_rvalid) begin
                    resp_data_d = ext_data;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            cross_q      <= 1'b0;
            word0_q      <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cross_q      <= cross_d;
            word0_q      <= word0_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_data     = resp_data_q;
    assign resp_fault    = resp_fault_q;

    always_comb begin
        case (state_q)
            ST_ACC0: mem_addr = base_q;
            ST_ACC1: mem_addr = base_q + ADDR_W'(W);
            default: mem_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (XLEN=32): one instance with misaligned
// splitting enabled and one with it disabled, sharing a single stimulus driver.
module tb_load_align_unit;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_ready;

    logic        a_req_ready, a_mem_req_valid, a_resp_valid, a_resp_fault;
    logic [31:0] a_mem_addr, a_resp_data;
    logic        b_req_ready, b_mem_req_valid, b_resp_valid, b_resp_fault;
    logic [31:0] b_mem_addr, b_resp_data;

    logic        o_req_ready, o_mem_req_valid, o_resp_valid, o_resp_fault;
    logic [31:0] o_mem_addr, o_resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid & ~sel),
        .req_ready     (a_req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .mem_req_valid (a_mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (a_mem_addr),
        .mem_rvalid    (mem_rvalid & ~sel),
        .mem_rdata     (mem_rdata),
        .resp_valid    (a_resp_valid),
        .resp_ready    (resp_ready & ~sel),
        .resp_data     (a_resp_data),
        .resp_fault    (a_resp_fault)
    );

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_nm (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid & sel),
        .req_ready     (b_req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .mem_req_valid (b_mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (b_mem_addr),
        .mem_rvalid    (mem_rvalid & sel),
        .mem_rdata     (mem_rdata),
        .resp_valid    (b_resp_valid),
        .resp_ready    (resp_ready & sel),
        .resp_data     (b_resp_data),
        .resp_fault    (b_resp_fault)
    );

    assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign o_mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
    assign o_mem_addr      = sel ? b_mem_addr      : a_mem_addr;
    assign o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
    assign o_resp_data     = sel ? b_resp_data     : a_resp_data;
    assign o_resp_fault    = sel ? b_resp_fault    : a_resp_fault;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait memory: ready always high, data valid the cycle after acceptance.
    task automatic run_load(input logic s, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] w0, input logic [31:0] w1, input int hold,
                            output int lat, output int nacc, output logic [31:0] a0,
                            output logic [31:0] a1, output logic [31:0] data, output logic fault);
        int held;
        bit seen, done, acc_prev;
        lat = 0; nacc = 0; a0 = '0; a1 = '0; data = '0; fault = 1'b0;
        held = 0; seen = 0; done = 0; acc_prev = 0;
        sel = s;
        #1;
        check_eq("req_ready_idle", 64'(o_req_ready), 64'd1);
        req_valid = 1'b1; req_addr = addr; req_funct3 = f3;
        @(posedge clk);
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            req_valid  = 1'b0;
            req_addr   = 32'h5A5A_5A5A;
            mem_rvalid = 1'b0;
            resp_ready = 1'b0;
            if (acc_prev) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (nacc == 1) ? w0 : w1;
                acc_prev   = 0;
            end
            if (o_mem_req_valid) begin
                if (nacc == 0) a0 = o_mem_addr;
                else           a1 = o_mem_addr;
                nacc++;
                acc_prev = 1;
            end
            if (o_resp_valid) begin
                if (!seen) begin
                    seen = 1; lat = n + 1; data = o_resp_data; fault = o_resp_fault;
                end else begin
                    check_eq("resp_data_stable", 64'(o_resp_data), 64'(data));
                    check_eq("resp_fault_stable", 64'(o_resp_fault), 64'(fault));
                end
                if (held >= hold) resp_ready = 1'b1;
                held++;
            end else if (seen) begin
                done = 1;
            end
            if (!done) @(posedge clk);
        end
        resp_ready = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("load_completed", 64'(done), 64'd1);
    endtask

    task automatic do_vec(input string tag, input logic s, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] w0, input logic [31:0] w1,
                          input int hold, input int e_lat, input int e_nacc,
                          input logic [31:0] e_a0, input logic [31:0] e_a1,
                          input logic [31:0] e_data, input logic e_fault);
        int lat, nacc;
        logic [31:0] a0, a1, data;
        logic fault;
        run_load(s, addr, f3, w0, w1, hold, lat, nacc, a0, a1, data, fault);
        check_eq({tag, "_data"},  64'(data),  64'(e_data));
        check_eq({tag, "_fault"}, 64'(fault), 64'(e_fault));
        check_eq({tag, "_lat"},   64'(lat),   64'(e_lat));
        check_eq({tag, "_nacc"},  64'(nacc),  64'(e_nacc));
        if (e_nacc > 0) check_eq({tag, "_addr0"}, 64'(a0), 64'(e_a0));
        if (e_nacc > 1) check_eq({tag, "_addr1"}, 64'(a1), 64'(e_a1));
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
        mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready",     64'(o_req_ready),     64'd1);
        check_eq("rst_mem_req_valid", 64'(o_mem_req_valid), 64'd0);
        check_eq("rst_mem_addr",      64'(o_mem_addr),      64'd0);
        check_eq("rst_resp_valid",    64'(o_resp_valid),    64'd0);
        check_eq("rst_resp_data",     64'(o_resp_data),     64'd0);
        check_eq("rst_resp_fault",    64'(o_resp_fault),    64'd0);
        reset = 1'b0;
        @(posedge clk);

        //     tag        sel   addr           f3      word0          word1         hold lat n  addr0          addr1          data           fault
        do_vec("lw",      1'b0, 32'h0000_0100, LW,     32'hDEADBEEF, 32'h0,        0,   3,  1, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 1'b0);
        do_vec("lb",      1'b0, 32'h0000_0103, LB,     32'h80112233, 32'h0,        0,   3,  1, 32'h0000_0100, 32'h0,         32'hFFFFFF80, 1'b0);
        do_vec("lbu",     1'b0, 32'h0000_0103, LBU,    32'h80112233, 32'h0,        0,   3,  1, 32'h0000_0100, 32'h0,         32'h00000080, 1'b0);
        do_vec("lh_x",    1'b0, 32'h0000_0103, LH,     32'hAA000000, 32'h000000BB, 0,   5,  2, 32'h0000_0100, 32'h0000_0104, 32'hFFFFBBAA, 1'b0);
        do_vec("lw_wrap", 1'b0, 32'hFFFF_FFFE, LW,     32'h11223344, 32'h55667788, 0,   5,  2, 32'hFFFF_FFFC, 32'h0000_0000, 32'h77881122, 1'b0);
        do_vec("lw_x1",   1'b0, 32'h0000_0201, LW,     32'h44332211, 32'h88776655, 0,   5,  2, 32'h0000_0200, 32'h0000_0204, 32'h55443322, 1'b0);
        do_vec("lh_hold", 1'b0, 32'h0000_0102, LH,     32'h80017777, 32'h0,        4,   3,  1, 32'h0000_0100, 32'h0,         32'hFFFF8001, 1'b0);
        do_vec("f3_011",  1'b0, 32'h0000_0100, 3'b011, 32'h0,        32'h0,        4,   1,  0, 32'h0,         32'h0,         32'h00000000, 1'b1);
        do_vec("f3_110",  1'b0, 32'h0000_0100, 3'b110, 32'h0,        32'h0,        0,   1,  0, 32'h0,         32'h0,         32'h00000000, 1'b1);
        do_vec("f3_111",  1'b0, 32'h0000_0104, 3'b111, 32'h0,        32'h0,        0,   1,  0, 32'h0,         32'h0,         32'h00000000, 1'b1);
        do_vec("nm_lw",   1'b1, 32'h0000_0101, LW,     32'h0,        32'h0,        0,   1,  0, 32'h0,         32'h0,         32'h00000000, 1'b1);
        do_vec("nm_lh",   1'b1, 32'h0000_0103, LH,     32'h0,        32'h0,        0,   1,  0, 32'h0,         32'h0,         32'h00000000, 1'b1);
        do_vec("nm_lhu",  1'b1, 32'h0000_0102, LHU,    32'h80017777, 32'h0,        0,   3,  1, 32'h0000_0100, 32'h0,         32'h00008001, 1'b0);

        // Reset while waiting for the second word of a crossing load.
        sel = 1'b0;
        #1;
        req_valid = 1'b1; req_addr = 32'h0000_0103; req_funct3 = LH;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rw_acc0", 64'(o_mem_req_valid), 64'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hAA000000;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_eq("rw_acc1_addr", 64'(o_mem_addr), 64'h104);
        @(posedge clk); #1;
        check_eq("rw_wait1_busy", 64'(o_req_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rw_idle_ready", 64'(o_req_ready),     64'd1);
        check_eq("rw_mem_valid",  64'(o_mem_req_valid), 64'd0);
        check_eq("rw_resp_valid", 64'(o_resp_valid),    64'd0);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check_eq("stale_ready",      64'(o_req_ready),  64'd1);
        check_eq("stale_resp_valid", 64'(o_resp_valid), 64'd0);
        @(posedge clk);

        do_vec("post_rst", 1'b0, 32'h0000_0300, LW, 32'hCAFEF00D, 32'h0, 0, 3, 1, 32'h0000_0300, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
